imu_exttime_multi: RTL and testbench
====================================

# imu_exttime_multi

Parametrised external-timestamp logger channel: accepts byte-serial 8-byte timestamp messages from NUM_CHN sensor channels, holds one completed message per channel, moves them by round-robin arbitration into a shared record FIFO, and presents 4×16-bit records to the logger readout. It sits between the sensor-channel timestamp outputs and the event-logger multiplexer. Every accepted record raises a one-cycle local timestamp request. The single clock domain removes the need for clock-crossing pulses.

## Interface
- NUM_CHN, 4: number of input channels, 1..8
- FIFO_DEPTH, 4: record FIFO depth in 4-word records, power of 2, 2..16
- mclk  input  1  system clock, all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- en_chn  input  NUM_CHN  per-channel enable; all 0 also flushes the record FIFO
- ts_stb  input  NUM_CHN  per-channel strobe, 1 cycle before byte 0
- ts_data  input  8*NUM_CHN  channel k byte on [8k+7:8k]
- ts  output  1  local timestamp request, 1-cycle pulse
- rdy  output  1  at least one complete record in the FIFO
- rd_stb  input  1  pop one 16-bit word
- rdata  output  16  head word of the FIFO (first-word-fall-through)
- drop_cnt  output  16  saturating count of dropped messages

## Operation
- Message format: ts_stb at cycle t; bytes 0..7 on t+1..t+8. Bytes 0-3 are seconds, LSB first. Bytes 4-7 are microseconds, LSB first; byte 7 is unused.
- Capture per channel: a 3-bit byte counter and a 64-bit shift register.
  - ts_stb (channel enabled) restarts the counter at byte 0, even mid-message.
  - After byte 7, the message is complete.
- Per-channel pending flag:
  - Set when a message completes and the flag is clear; the 64-bit value is latched into the hold register.
  - If a message completes while the flag is already set, it is dropped and drop_cnt increments. drop_cnt saturates at 0xFFFF.
  - If several channels drop in the same cycle, drop_cnt increments by 1 per channel (up to NUM_CHN).
- Channel disable: clears pending, byte counter and capture for that channel in the next cycle. A disabled channel ignores ts_stb.
- Arbiter states:
  - IDLE: when any pending flag is set and the FIFO has at least 1 free record, grant the lowest pending channel index at or after last_grant+1 (mod NUM_CHN). Then go to COPY and pulse ts.
  - COPY: 4 cycles writing words w0..w3. Clear the granted pending flag on the first COPY cycle, then return to IDLE.
- Record words:
  - w0 = usec[15:0]
  - w1 = {5'b0, chn[2:0], usec[23:16]}; the channel number replaces byte 7
  - w2 = sec[15:0]
  - w3 = sec[31:16]
- FIFO: FIFO_DEPTH*4 words, with a word write pointer, read pointer and complete-record counter. rec_cnt increments on the w3 write cycle and decrements on the pop of a w3 word.
- Readout:
  - rdy = (rec_cnt != 0).
  - rd_stb while rdy=0 is ignored.
  - rd_stb on a w3 with rec_cnt=1 drops rdy in the next cycle.
  - The host reads whole records only.
- All en_chn=0: FIFO pointers, rec_cnt, pending flags and arbiter are reset synchronously. drop_cnt is preserved and is cleared only by rst_n.
- A channel disabled during COPY of its record does not abort that COPY; the record completes.

## Timing
- Reset values: ts=0, rdy=0, rdata=0, drop_cnt=0, all pending=0, arbiter IDLE, last_grant=NUM_CHN-1.
- Latency with the FIFO free:
  - ts_stb at t; byte 7 at t+8.
  - pending=1 at t+9.
  - Grant and ts=1 at t+10.
  - Words written t+10..t+13.
  - rdy=1 at t+14.
- Arbiter throughput: 1 record per 5 cycles (4 COPY + 1 IDLE).
- FIFO full (rec_cnt=FIFO_DEPTH): no grant. Pending stays set, and later messages on that channel are dropped.
- Simultaneous write of w3 and pop of w3: rec_cnt unchanged.
- Pointers wrap modulo FIFO_DEPTH*4.
- Mid-operation rst_n: all state clears immediately and asynchronously.

## Test plan
- Ch0 message sec=0x12345678, usec=0x000ABCDE: ts pulse at t+10, rdy at t+14. Reads give 0xBCDE, 0x000A, 0x5678, 0x1234.
- Ch1 and ch3 complete in the same cycle, last_grant=1: ch3 is granted first, then ch1. w1 upper bytes are 0x03 then 0x01. Exactly 2 ts pulses, 5 cycles apart.
- FIFO_DEPTH=4: 5 messages on channels 0..3 and 0, no reads. 4 records are stored and ch0 stays pending. A 6th ch0 message gives drop_cnt=1. Reading one record lets the pending ch0 record enter.
- ts_stb on ch2 again at byte 4: the first message is discarded, only the second is recorded, and drop_cnt is unchanged.
- rd_stb with rdy=0: no pointer change, rdata unchanged.
- en_chn goes 0 with 2 records stored: rdy=0 the next cycle. drop_cnt is retained; after rst_n=0, drop_cnt=0.

Source files
------------

// File: rtl/imu_exttime_multi_if.sv
// Signal bundle between the sensor channels, the logger readout and imu_exttime_multi.
// The design uses the slave modport and the channel/host side uses the master modport.
interface imu_exttime_multi_if #(
  parameter int NUM_CHN = 4
);
  logic [NUM_CHN-1:0]   en_chn;
  logic [NUM_CHN-1:0]   ts_stb;
  logic [8*NUM_CHN-1:0] ts_data;
  logic                 ts;
  logic                 rdy;
  logic                 rd_stb;
  logic [15:0]          rdata;
  logic [15:0]          drop_cnt;

  modport master (
    output en_chn, ts_stb, ts_data, rd_stb,
    input  ts, rdy, rdata, drop_cnt
  );

  modport slave (
    input  en_chn, ts_stb, ts_data, rd_stb,
    output ts, rdy, rdata, drop_cnt
  );
endinterface

// File: rtl/imu_exttime_multi.sv
// Multi-channel external timestamp logger: byte-serial capture per channel, round-robin
// copy of completed messages into a shared FIFO of 4-word records, first-word-fall-through readout.
module imu_exttime_multi #(
  parameter int NUM_CHN    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               mclk,
  input  logic               rst_n,
  imu_exttime_multi_if.slave bus
);
  localparam int CW = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
  localparam int AW = $clog2(FIFO_DEPTH * 4);
  localparam int RW = $clog2(FIFO_DEPTH + 1);
  localparam int NW = FIFO_DEPTH * 4;

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_COPY  = 1'b1;
  localparam logic [CW-1:0] LAST_CHN = CW'(NUM_CHN - 1);
  localparam logic [RW-1:0] REC_FULL = RW'(FIFO_DEPTH);
  localparam logic [RW-1:0] REC_ONE  = RW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  function automatic logic [3:0] popcount(input logic [NUM_CHN-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_CHN; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  logic               srst_s;
  logic [NUM_CHN-1:0] busy_r;
  logic [NUM_CHN-1:0] pend_r;
  logic [2:0]         cnt_r  [NUM_CHN];
  logic [55:0]        sr_r   [NUM_CHN];
  logic [55:0]        hold_r [NUM_CHN];
  logic [63:0]        msg_s  [NUM_CHN];
  logic [NUM_CHN-1:0] done_s;
  logic [NUM_CHN-1:0] drop_s;
  logic [NUM_CHN-1:0] clr_s;

  logic [0:0]         state_r;
  logic [1:0]         wc_r;
  logic [CW-1:0]      gnt_r;
  logic [CW-1:0]      last_r;
  logic [55:0]        cpy_r;
  logic               ts_r;
  logic [CW-1:0]      sel_s;
  logic               sel_vld_s;
  logic               grant_s;

  logic [15:0]        mem_r [NW];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [RW-1:0]      rec_cnt_r;
  logic               wr_en_s;
  logic               wr_last_s;
  logic               pop_s;
  logic               pop_last_s;
  logic [15:0]        wdata_s;
  logic [15:0]        drop_r;
  logic [16:0]        drop_sum_s;

  assign srst_s = (bus.en_chn == {NUM_CHN{1'b0}});

  // Per-channel message assembly and completion/drop detection
  always_comb begin
    for (int k = 0; k < NUM_CHN; k++) begin
      msg_s[k]  = {bus.ts_data[8*k +: 8], sr_r[k]};
      done_s[k] = bus.en_chn[k] & ~bus.ts_stb[k] & busy_r[k] & (cnt_r[k] == 3'd7);
      drop_s[k] = done_s[k] & pend_r[k];
    end
  end

  // Granted channel's pending flag is released on the first COPY cycle
  always_comb begin
    clr_s        = {NUM_CHN{1'b0}};
    clr_s[gnt_r] = (state_r == ST_COPY) && (wc_r == 2'd0);
  end

  // Capture shift registers, byte counters, pending flags and hold registers
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {NUM_CHN{1'b0}};
      pend_r <= {NUM_CHN{1'b0}};
      for (int k = 0; k < NUM_CHN; k++) begin
        cnt_r[k]  <= 3'd0;
        sr_r[k]   <= 56'd0;
        hold_r[k] <= 56'd0;
      end
    end else begin
      for (int k = 0; k < NUM_CHN; k++) begin
        if (!bus.en_chn[k]) begin
          busy_r[k] <= 1'b0;
          pend_r[k] <= 1'b0;
          cnt_r[k]  <= 3'd0;
          sr_r[k]   <= 56'd0;
        end else begin
          if (bus.ts_stb[k]) begin
            busy_r[k] <= 1'b1;
            cnt_r[k]  <= 3'd0;
          end else if (busy_r[k]) begin
            sr_r[k]  <= msg_s[k][63:8];
            cnt_r[k] <= cnt_r[k] + 3'd1;
            if (cnt_r[k] == 3'd7) begin
              busy_r[k] <= 1'b0;
            end
          end
          if (done_s[k] && !pend_r[k]) begin
            pend_r[k] <= 1'b1;
            hold_r[k] <= msg_s[k][55:0];
          end else if (clr_s[k]) begin
            pend_r[k] <= 1'b0;
          end
        end
      end
    end
  end

  // Round-robin pick: nearest pending channel after last_r wins (loop runs far to near)
  always_comb begin
    int            idx;
    logic [CW-1:0] pos;
    logic          hit;
    sel_s     = LAST_CHN;
    sel_vld_s = 1'b0;
    idx       = 0;
    pos       = {CW{1'b0}};
    hit       = 1'b0;
    for (int i = NUM_CHN; i >= 1; i--) begin
      idx       = int'(last_r) + i;
      idx       = (idx >= NUM_CHN) ? (idx - NUM_CHN) : idx;
      pos       = CW'(idx);
      hit       = pend_r[pos];
      sel_s     = hit ? pos : sel_s;
      sel_vld_s = sel_vld_s | hit;
    end
  end

  assign grant_s = (state_r == ST_IDLE) && sel_vld_s && (rec_cnt_r < REC_FULL) && !srst_s;

  // Arbiter FSM; the granted record is snapshotted so later captures cannot disturb the copy
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      wc_r    <= 2'd0;
      gnt_r   <= {CW{1'b0}};
      last_r  <= LAST_CHN;
      cpy_r   <= 56'd0;
      ts_r    <= 1'b0;
    end else if (srst_s) begin
      state_r <= ST_IDLE;
      wc_r    <= 2'd0;
      gnt_r   <= {CW{1'b0}};
      last_r  <= LAST_CHN;
      ts_r    <= 1'b0;
    end else begin
      ts_r <= grant_s;
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            state_r <= ST_COPY;
            wc_r    <= 2'd0;
            gnt_r   <= sel_s;
            last_r  <= sel_s;
            cpy_r   <= hold_r[sel_s];
          end
        end
        ST_COPY: begin
          wc_r <= wc_r + 2'd1;
          if (wc_r == 2'd3) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          wc_r    <= 2'd0;
        end
      endcase
    end
  end

  // Record word for the current COPY cycle; the channel number takes the unused byte 7
  always_comb begin
    case (wc_r)
      2'd0:    wdata_s = cpy_r[47:32];
      2'd1:    wdata_s = {5'b00000, 3'(gnt_r), cpy_r[55:48]};
      2'd2:    wdata_s = cpy_r[15:0];
      2'd3:    wdata_s = cpy_r[31:16];
      default: wdata_s = 16'h0000;
    endcase
  end

  assign wr_en_s    = (state_r == ST_COPY) && !srst_s;
  assign wr_last_s  = wr_en_s && (wc_r == 2'd3);
  assign pop_s      = bus.rd_stb && (rec_cnt_r != {RW{1'b0}}) && !srst_s;
  assign pop_last_s = pop_s && (rd_ptr_r[1:0] == 2'd3);

  // Record FIFO storage, pointers and complete-record counter
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) begin
        mem_r[i] <= 16'h0000;
      end
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      rec_cnt_r <= {RW{1'b0}};
    end else if (srst_s) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      rec_cnt_r <= {RW{1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= wdata_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_last_s, pop_last_s})
        2'b10:   rec_cnt_r <= rec_cnt_r + REC_ONE;
        2'b01:   rec_cnt_r <= rec_cnt_r - REC_ONE;
        default: rec_cnt_r <= rec_cnt_r;
      endcase
    end
  end

  assign drop_sum_s = {1'b0, drop_r} + 17'(popcount(drop_s));

  // Saturating drop counter; survives the all-disabled flush, cleared only by rst_n
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      drop_r <= 16'h0000;
    end else begin
      drop_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
    end
  end

  assign bus.ts       = ts_r;
  assign bus.rdy      = (rec_cnt_r != {RW{1'b0}});
  assign bus.rdata    = mem_r[rd_ptr_r];
  assign bus.drop_cnt = drop_r;
endmodule

// File: tb/tb_imu_exttime_multi.sv
// Directed bench for imu_exttime_multi: expected record words are queued when messages
// are sent and compared at readout; a small memory model tracks the idle head word.
module tb_imu_exttime_multi;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int NW    = DEPTH * 4;

  logic mclk  = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] exp_q [$];
  logic [15:0] model_mem [NW];
  int          mwr = 0;
  int          mrd = 0;

  imu_exttime_multi_if #(.NUM_CHN(NCH)) bus ();

  imu_exttime_multi #(.NUM_CHN(NCH), .FIFO_DEPTH(DEPTH)) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  function automatic logic [63:0] mk(input logic [31:0] sec, input logic [23:0] usec);
    return {8'hA5, usec, sec};
  endfunction

  task automatic push_rec(input int ch, input logic [63:0] m);
    logic [2:0]  c3;
    logic [15:0] w [4];
    c3   = 3'(ch);
    w[0] = m[47:32];
    w[1] = {5'b00000, c3, m[55:48]};
    w[2] = m[15:0];
    w[3] = m[31:16];
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(w[i]);
      model_mem[mwr] = w[i];
      mwr = (mwr + 1) % NW;
    end
  endtask

  task automatic send(input logic [NCH-1:0] mask, input logic [NCH-1:0][63:0] msgs);
    bus.ts_stb = mask;
    tick();
    bus.ts_stb = {NCH{1'b0}};
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < NCH; k++) begin
        bus.ts_data[8*k +: 8] = msgs[k][8*b +: 8];
      end
      tick();
    end
  endtask

  task automatic wait_rdy(input string tag);
    int n;
    n = 0;
    while (bus.rdy !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, {31'd0, bus.rdy}, 32'd1);
  endtask

  task automatic read_rec(input string tag);
    logic [15:0] e;
    wait_rdy(tag);
    for (int w = 0; w < 4; w++) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else                   e = 16'hDEAD;
      bus.rd_stb = 1'b1;
      check($sformatf("%s_w%0d", tag, w), {16'd0, bus.rdata}, {16'd0, e});
      tick();
      mrd = (mrd + 1) % NW;
    end
    bus.rd_stb = 1'b0;
  endtask

  initial begin
    logic [NCH-1:0][63:0] msgs;
    logic [63:0]          m;
    logic [63:0]          ma;
    logic [63:0]          m5;
    int                   np;
    int                   first;
    int                   second;

    for (int i = 0; i < NW; i++) model_mem[i] = 16'h0000;
    bus.en_chn  = {NCH{1'b0}};
    bus.ts_stb  = {NCH{1'b0}};
    bus.ts_data = {8*NCH{1'b0}};
    bus.rd_stb  = 1'b0;
    repeat (2) @(posedge mclk);
    #1;
    check("rst_ts",   {31'd0, bus.ts},       32'd0);
    check("rst_rdy",  {31'd0, bus.rdy},      32'd0);
    check("rst_rdata",{16'd0, bus.rdata},    32'd0);
    check("rst_drop", {16'd0, bus.drop_cnt}, 32'd0);
    rst_n = 1'b1;
    bus.en_chn = 4'hF;
    tick();

    // single ch0 message with latency checkpoints
    msgs = '0;
    m = mk(32'h12345678, 24'h0ABCDE);
    msgs[0] = m;
    push_rec(0, m);
    send(4'b0001, msgs);
    check("t1_ts_t9", {31'd0, bus.ts}, 32'd0);
    tick();
    check("t1_ts_t10", {31'd0, bus.ts}, 32'd1);
    tick();
    check("t1_ts_t11", {31'd0, bus.ts}, 32'd0);
    tick();
    tick();
    check("t1_rdy_t13", {31'd0, bus.rdy}, 32'd0);
    tick();
    check("t1_rdy_t14", {31'd0, bus.rdy}, 32'd1);
    read_rec("t1");
    check("t1_rdy_after", {31'd0, bus.rdy}, 32'd0);

    // ch1 alone so that last grant = 1, then ch1 and ch3 together
    msgs = '0;
    m = mk(32'h01020304, 24'h050607);
    msgs[1] = m;
    push_rec(1, m);
    send(4'b0010, msgs);
    read_rec("t2a");
    msgs = '0;
    msgs[1] = mk(32'hA1A2A3A4, 24'hB1B2B3);
    msgs[3] = mk(32'hC1C2C3C4, 24'hD1D2D3);
    push_rec(3, msgs[3]);
    push_rec(1, msgs[1]);
    send(4'b1010, msgs);
    np = 0;
    first = -1;
    second = -1;
    for (int c = 0; c < 15; c++) begin
      if (bus.ts === 1'b1) begin
        if (np == 0) first = c;
        else if (np == 1) second = c;
        np++;
      end
      tick();
    end
    check("t2_ts_count", np, 32'd2);
    check("t2_ts_gap", second - first, 32'd5);
    read_rec("t2_ch3");
    read_rec("t2_ch1");

    // fill the FIFO: grant order after last grant 1 is 2,3,0,1
    for (int k = 0; k < NCH; k++) msgs[k] = mk(32'h10000000 + 32'(k), 24'h200000 + 24'(k));
    push_rec(2, msgs[2]);
    push_rec(3, msgs[3]);
    push_rec(0, msgs[0]);
    push_rec(1, msgs[1]);
    send(4'b1111, msgs);
    repeat (25) tick();
    m5 = mk(32'h55555555, 24'h555555);
    msgs = '0;
    msgs[0] = m5;
    send(4'b0001, msgs);
    repeat (10) tick();
    check("t3_full_rdy", {31'd0, bus.rdy}, 32'd1);
    check("t3_drop0", {16'd0, bus.drop_cnt}, 32'd0);
    msgs[0] = mk(32'h66666666, 24'h666666);
    send(4'b0001, msgs);
    check("t3_drop1", {16'd0, bus.drop_cnt}, 32'd1);
    read_rec("t3_r0");
    push_rec(0, m5);
    read_rec("t3_r1");
    read_rec("t3_r2");
    read_rec("t3_r3");
    read_rec("t3_r4");
    repeat (8) tick();
    check("t3_empty", {31'd0, bus.rdy}, 32'd0);

    // ch2 restarted at byte 4: only the second message counts
    ma = mk(32'hDEADBEEF, 24'h123456);
    bus.ts_stb = 4'b0100;
    tick();
    bus.ts_stb = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      bus.ts_data[23:16] = ma[8*b +: 8];
      tick();
    end
    msgs = '0;
    msgs[2] = mk(32'h0BADF00D, 24'h654321);
    push_rec(2, msgs[2]);
    send(4'b0100, msgs);
    read_rec("t4");
    repeat (10) tick();
    check("t4_no_extra", {31'd0, bus.rdy}, 32'd0);
    check("t4_drop", {16'd0, bus.drop_cnt}, 32'd1);

    // rd_stb while empty is ignored
    bus.rd_stb = 1'b1;
    tick();
    tick();
    bus.rd_stb = 1'b0;
    check("t5_rdy", {31'd0, bus.rdy}, 32'd0);
    check("t5_rdata", {16'd0, bus.rdata}, {16'd0, model_mem[mrd]});
    msgs = '0;
    msgs[1] = mk(32'h0F0E0D0C, 24'h0B0A09);
    push_rec(1, msgs[1]);
    send(4'b0010, msgs);
    read_rec("t5");

    // all channels disabled flushes the FIFO but keeps drop_cnt
    msgs = '0;
    msgs[0] = mk(32'h77777777, 24'h777777);
    msgs[1] = mk(32'h88888888, 24'h888888);
    push_rec(0, msgs[0]);
    push_rec(1, msgs[1]);
    send(4'b0011, msgs);
    repeat (12) tick();
    check("t6_rdy_before", {31'd0, bus.rdy}, 32'd1);
    bus.en_chn = 4'h0;
    tick();
    exp_q.delete();
    mwr = 0;
    mrd = 0;
    check("t6_rdy_flush", {31'd0, bus.rdy}, 32'd0);
    check("t6_drop_kept", {16'd0, bus.drop_cnt}, 32'd1);
    check("t6_rdata_slot0", {16'd0, bus.rdata}, {16'd0, model_mem[0]});
    rst_n = 1'b0;
    #1;
    check("t6_drop_rst", {16'd0, bus.drop_cnt}, 32'd0);
    check("t6_rdata_rst", {16'd0, bus.rdata}, 32'd0);
    for (int i = 0; i < NW; i++) model_mem[i] = 16'h0000;
    tick();
    rst_n = 1'b1;
    bus.en_chn = 4'hF;
    tick();
    msgs = '0;
    msgs[2] = mk(32'h9ABCDEF0, 24'h13579B);
    push_rec(2, msgs[2]);
    send(4'b0100, msgs);
    read_rec("t7");
    check("q_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
